xmr_assert_monitor: RTL and testbench

// - Bind-in checker for N observed channels: per channel, O must equal I delayed by LATENCY cycles

---
 rtl/xmr_monitor_pkg.sv | 19 +
 rtl/xmr_monitor_delay_line.sv | 62 ++++++
 rtl/xmr_assert_monitor.sv | 174 +++++++++++++++++
 tb/tb_xmr_assert_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmr_monitor_pkg.sv
// xmr_monitor_pkg
// Shared types and helpers for the bind-in latency checker.
//   mon_state_t  : checker FSM states (IDLE, FILL, CHECK)
//   MAX_LATENCY  : largest supported I->O delay; sizes the fill counter
//   clog2_min1() : ceil(log2(n)) but never less than one bit, so that
//                  index ports stay legal when there is a single channel
package xmr_monitor_pkg;

    typedef enum logic [1:0] {IDLE, FILL, CHECK} mon_state_t;

    localparam int MAX_LATENCY = 15;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/xmr_monitor_delay_line.sv
// xmr_monitor_delay_line
// One channel's history: a W-bit x LATENCY shift register with a valid bit
// per stage. The last stage holds the input from exactly LATENCY shifts ago.
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_shift        : push i_data into the line this cycle
//   i_flush        : drop all history (valid bits cleared, data left as is)
//   i_data         : value to push
//   o_data         : oldest stage (depth LATENCY)
//   o_valid        : o_data holds a real sample from the current run
// LATENCY=0 turns the line into a wire with o_valid tied high.
module xmr_monitor_delay_line #(
    parameter int W       = 8,
    parameter int LATENCY = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_shift,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    generate
        if (LATENCY == 0) begin : g_pass
            // Same-cycle compare: nothing is stored, so the control inputs
            // are deliberately ignored.
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst_n, i_shift, i_flush};
            assign o_data   = i_data;
            assign o_valid  = 1'b1;
        end else begin : g_line
            logic [W-1:0]       r_stage [LATENCY];
            logic [LATENCY-1:0] r_valid;

            // Flush wins over shift so a disabled monitor never carries a
            // stale sample into the next run.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int s = 0; s < LATENCY; s++) begin
                        r_stage[s] <= '0;
                    end
                    r_valid <= '0;
                end else if (i_flush) begin
                    r_valid <= '0;
                end else if (i_shift) begin
                    r_stage[0] <= i_data;
                    r_valid[0] <= 1'b1;
                    for (int s = 1; s < LATENCY; s++) begin
                        r_stage[s] <= r_stage[s-1];
                        r_valid[s] <= r_valid[s-1];
                    end
                end
            end

            assign o_data  = r_stage[LATENCY-1];
            assign o_valid = r_valid[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/xmr_assert_monitor.sv
// xmr_assert_monitor
// Bind-in checker: per channel k, O_k must equal I_k delayed by LATENCY
// cycles whenever other[k] is high. Purely observational.
// Ports:
//   CLK, ASYNCRESETN : clock and asynchronous active-low reset
//   en               : monitor enable; low discards history and idles
//   clear            : synchronous clear of flags, counts and capture
//   I, O             : observed inputs/outputs, channel k at [k*W +: W]
//   other            : per-channel check qualifier
//   fail             : OR of fail_mask
//   fail_mask        : sticky per-channel mismatch flags
//   err_count        : per-channel saturating mismatch counts
//   first_valid      : a first-failure record is held
//   first_chan       : lowest mismatching channel of the first failure
//   first_cycle      : cycle stamp of the first failure
module xmr_assert_monitor
    import xmr_monitor_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W       = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8,
    parameter int CYC_W   = 32
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESETN,
    input  logic                        en,
    input  logic                        clear,
    input  logic [N_CH*W-1:0]           I,
    input  logic [N_CH*W-1:0]           O,
    input  logic [N_CH-1:0]             other,
    output logic                        fail,
    output logic [N_CH-1:0]             fail_mask,
    output logic [N_CH*CNT_W-1:0]       err_count,
    output logic                        first_valid,
    output logic [clog2_min1(N_CH)-1:0] first_chan,
    output logic [CYC_W-1:0]            first_cycle
);

    localparam int CH_W   = clog2_min1(N_CH);
    localparam int FILL_W = clog2_min1(MAX_LATENCY + 1);

    mon_state_t        r_state;
    mon_state_t        w_nextState;
    logic [FILL_W-1:0] r_fillCnt;
    logic [FILL_W-1:0] w_nextFillCnt;
    logic              w_checkActive;
    logic [CYC_W-1:0]  r_stamp;
    logic [W-1:0]      w_histData [N_CH];
    logic [N_CH-1:0]   w_histValid;
    logic [N_CH-1:0]   w_mismatch;
    logic [CH_W-1:0]   w_firstIdx;

    // One history line per channel. History moves only while enabled and
    // is discarded the moment en drops, forcing a full refill afterwards.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        xmr_monitor_delay_line #(
            .W       (W),
            .LATENCY (LATENCY)
        ) u_delay (
            .i_clk   (CLK),
            .i_rst_n (ASYNCRESETN),
            .i_shift (en),
            .i_flush (!en),
            .i_data  (I[k*W +: W]),
            .o_data  (w_histData[k]),
            .o_valid (w_histValid[k])
        );

        assign w_mismatch[k] = w_checkActive && other[k] && w_histValid[k] &&
                               (O[k*W +: W] != w_histData[k]);
    end

    // Next-state logic. FILL lasts exactly LATENCY enabled cycles so the
    // deepest stage is populated before the first compare. With LATENCY=0
    // there is nothing to wait for: the first enabled cycle out of IDLE
    // already compares and the machine settles in CHECK.
    always_comb begin
        w_nextState   = r_state;
        w_nextFillCnt = r_fillCnt;
        w_checkActive = 1'b0;
        if (!en) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (LATENCY == 0) begin
                        w_nextState   = CHECK;
                        w_checkActive = 1'b1;
                    end else begin
                        w_nextState   = FILL;
                        w_nextFillCnt = '0;
                    end
                end
                FILL: begin
                    if (r_fillCnt == FILL_W'(LATENCY - 1)) begin
                        w_nextState = CHECK;
                    end else begin
                        w_nextFillCnt = r_fillCnt + FILL_W'(1);
                    end
                end
                CHECK: begin
                    w_checkActive = 1'b1;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // State register, fill counter and the free-running cycle stamp. The
    // stamp only advances while enabled and sticks at all-ones.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state   <= IDLE;
            r_fillCnt <= '0;
            r_stamp   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_fillCnt <= w_nextFillCnt;
            if (en && (r_stamp != {CYC_W{1'b1}})) begin
                r_stamp <= r_stamp + CYC_W'(1);
            end
        end
    end

    // Lowest-index mismatching channel wins the first-failure capture.
    always_comb begin
        w_firstIdx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_mismatch[k]) begin
                w_firstIdx = CH_W'(k);
            end
        end
    end

    // Failure bookkeeping. clear takes priority, so a mismatch seen in the
    // same cycle as clear leaves no trace. The capture is write-once until
    // the next clear or reset.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            fail_mask   <= '0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_chan  <= '0;
            first_cycle <= '0;
        end else if (clear) begin
            fail_mask   <= '0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_chan  <= '0;
            first_cycle <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_mismatch[k]) begin
                    fail_mask[k] <= 1'b1;
                    if (err_count[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                        err_count[k*CNT_W +: CNT_W] <=
                            err_count[k*CNT_W +: CNT_W] + CNT_W'(1);
                    end
                end
            end
            if (!first_valid && (|w_mismatch)) begin
                first_valid <= 1'b1;
                first_chan  <= w_firstIdx;
                first_cycle <= r_stamp;
            end
        end
    end

    assign fail = |fail_mask;

endmodule

// File: tb/tb_xmr_assert_monitor.sv
// tb_xmr_assert_monitor
// Drives two monitors from the same I/en/clear/other stimulus:
//   dutA : LATENCY=2, CNT_W=4 (O fed with I delayed two cycles)
//   dutB : LATENCY=0, CNT_W=8 (O fed with I of the same cycle)
// A reference model tracks the enabled run length and a queue of past
// inputs, and every cycle the DUT outputs are compared to it. Directed
// phases add hand-computed checks at the interesting points.
module tb_xmr_assert_monitor;

    logic        CLK;
    logic        ASYNCRESETN;
    logic        en;
    logic        clear;
    logic [31:0] I;
    logic [31:0] oA;
    logic [31:0] oB;
    logic [3:0]  other;

    logic        failA, failB;
    logic [3:0]  maskA, maskB;
    logic [15:0] errA;
    logic [31:0] errB;
    logic        fvA, fvB;
    logic [1:0]  fcA, fcB;
    logic [31:0] fcycA, fcycB;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] stepCnt;
    logic [31:0] p1, p2;

    xmr_assert_monitor #(
        .N_CH(4), .W(8), .LATENCY(2), .CNT_W(4), .CYC_W(32)
    ) dutA (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .clear(clear),
        .I(I), .O(oA), .other(other),
        .fail(failA), .fail_mask(maskA), .err_count(errA),
        .first_valid(fvA), .first_chan(fcA), .first_cycle(fcycA)
    );

    xmr_assert_monitor #(
        .N_CH(4), .W(8), .LATENCY(0), .CNT_W(8), .CYC_W(32)
    ) dutB (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .clear(clear),
        .I(I), .O(oB), .other(other),
        .fail(failB), .fail_mask(maskB), .err_count(errB),
        .first_valid(fvB), .first_chan(fcB), .first_cycle(fcycB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    logic [31:0] hq[$];
    int          runLen;
    int          mStamp;
    logic [3:0]  expMask [2];
    int          expCnt  [2][4];
    logic        expFv   [2];
    int          expFc   [2];
    int          expFcyc [2];
    logic [3:0]  mm;
    logic [31:0] refV, obsV;
    int          lat, cntMax;
    logic        active;

    task automatic modelReset();
        hq.delete();
        runLen = 0;
        mStamp = 0;
        for (int d = 0; d < 2; d++) begin
            expMask[d] = '0;
            expFv[d]   = 1'b0;
            expFc[d]   = 0;
            expFcyc[d] = 0;
            for (int k = 0; k < 4; k++) expCnt[d][k] = 0;
        end
    endtask

    // A channel is judged in cycle t only if en has been high long enough:
    // one idle cycle plus `lat` fill cycles before the first compare, or
    // immediately for a zero-latency monitor.
    task automatic modelStep();
        runLen = en ? runLen + 1 : 0;
        for (int d = 0; d < 2; d++) begin
            lat    = (d == 0) ? 2 : 0;
            cntMax = (d == 0) ? 15 : 255;
            obsV   = (d == 0) ? oA : oB;
            active = en && ((lat == 0) ? (runLen >= 1) : (runLen >= lat + 2));
            mm     = '0;
            if (active) begin
                refV = (lat == 0) ? I : hq[hq.size() - lat];
                for (int k = 0; k < 4; k++) begin
                    if (other[k] && (refV[k*8 +: 8] != obsV[k*8 +: 8])) mm[k] = 1'b1;
                end
            end
            if (clear) begin
                expMask[d] = '0;
                expFv[d]   = 1'b0;
                expFc[d]   = 0;
                expFcyc[d] = 0;
                for (int k = 0; k < 4; k++) expCnt[d][k] = 0;
            end else if (mm != 4'b0) begin
                expMask[d] = expMask[d] | mm;
                for (int k = 0; k < 4; k++) begin
                    if (mm[k] && expCnt[d][k] < cntMax) expCnt[d][k] = expCnt[d][k] + 1;
                end
                if (!expFv[d]) begin
                    expFv[d]   = 1'b1;
                    expFcyc[d] = mStamp;
                    for (int k = 3; k >= 0; k--) if (mm[k]) expFc[d] = k;
                end
            end
        end
        if (en) begin
            hq.push_back(I);
            if (hq.size() > 16) void'(hq.pop_front());
            mStamp = mStamp + 1;
        end else begin
            hq.delete();
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge CLK or negedge ASYNCRESETN);
            if (!ASYNCRESETN) modelReset();
            else modelStep();
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("A.fail", 32'(failA), 32'(|expMask[0]));
        checkOutput("A.fail_mask", 32'(maskA), 32'(expMask[0]));
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("A.err_count[%0d]", k), 32'(errA[k*4 +: 4]), expCnt[0][k]);
        checkOutput("A.first_valid", 32'(fvA), 32'(expFv[0]));
        checkOutput("A.first_chan", 32'(fcA), expFc[0]);
        checkOutput("A.first_cycle", fcycA, expFcyc[0]);
        checkOutput("B.fail", 32'(failB), 32'(|expMask[1]));
        checkOutput("B.fail_mask", 32'(maskB), 32'(expMask[1]));
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("B.err_count[%0d]", k), 32'(errB[k*8 +: 8]), expCnt[1][k]);
        checkOutput("B.first_valid", 32'(fvB), 32'(expFv[1]));
        checkOutput("B.first_chan", 32'(fcB), expFc[1]);
        checkOutput("B.first_cycle", fcycB, expFcyc[1]);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            compareModel();
        end
    end

    // ---------------- stimulus ----------------
    // One call = one clock cycle. dutA's O is I from two calls ago, dutB's
    // O is this call's I; cA/cB flip bits to plant mismatches.
    task automatic applyStimulus(input logic e, input logic clr, input logic [3:0] oth,
                                 input logic [31:0] cA, input logic [31:0] cB);
        @(negedge CLK);
        stepCnt = stepCnt + 32'd1;
        p2      = p1;
        p1      = I;
        I       = stepCnt * 32'h9E3779B1 + 32'h13579BDF;
        oA      = p2 ^ cA;
        oB      = I ^ cB;
        en      = e;
        clear   = clr;
        other   = oth;
    endtask

    task automatic afterEdge();
        @(posedge CLK);
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " A.fail"}, 32'(failA), 32'h0);
        checkOutput({tag, " A.fail_mask"}, 32'(maskA), 32'h0);
        checkOutput({tag, " A.err_count"}, 32'(errA), 32'h0);
        checkOutput({tag, " A.first_valid"}, 32'(fvA), 32'h0);
        checkOutput({tag, " A.first_chan"}, 32'(fcA), 32'h0);
        checkOutput({tag, " A.first_cycle"}, fcycA, 32'h0);
        checkOutput({tag, " B.fail_mask"}, 32'(maskB), 32'h0);
        checkOutput({tag, " B.err_count"}, errB, 32'h0);
        checkOutput({tag, " B.first_valid"}, 32'(fvB), 32'h0);
        checkOutput({tag, " B.first_cycle"}, fcycB, 32'h0);
    endtask

    // Reset asserted between clock edges; outputs must drop at once.
    task automatic pulseReset(input string tag);
        @(negedge CLK);
        en    = 1'b0;
        clear = 1'b0;
        #2 ASYNCRESETN = 1'b0;
        #1 checkAllZero(tag);
        #1 ASYNCRESETN = 1'b1;
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        en          = 1'b0;
        clear       = 1'b0;
        other       = 4'hF;
        I           = '0;
        oA          = '0;
        oB          = '0;
        p1          = '0;
        p2          = '0;
        stepCnt     = '0;

        repeat (3) applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        #1 checkAllZero("reset");

        // Clean traffic: nothing may be flagged.
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        afterEdge();
        checkOutput("match A.fail", 32'(failA), 32'h0);
        checkOutput("match B.fail", 32'(failB), 32'h0);
        checkOutput("match A.first_valid", 32'(fvA), 32'h0);

        // Fresh start; stamp 0 is the first enabled cycle after this.
        pulseReset("reset1");

        // Single error on channel 2 at stamp 20, visible one cycle later.
        for (int i = 0; i <= 24; i++) begin
            applyStimulus(1'b1, 1'b0, 4'hF, (i == 20) ? 32'h0001_0000 : 32'h0, 32'h0);
            if (i == 20) begin
                checkOutput("single pre-edge A.fail_mask", 32'(maskA), 32'h0);
                afterEdge();
                checkOutput("single A.fail_mask", 32'(maskA), 32'h4);
                checkOutput("single A.err_count[2]", 32'(errA[11:8]), 32'd1);
                checkOutput("single A.first_valid", 32'(fvA), 32'd1);
                checkOutput("single A.first_chan", 32'(fcA), 32'd2);
                checkOutput("single A.first_cycle", fcycA, 32'd20);
            end
        end

        // Stamp 25: clear wipes the record.
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
        afterEdge();
        checkOutput("clear A.fail_mask", 32'(maskA), 32'h0);
        checkOutput("clear A.first_valid", 32'(fvA), 32'h0);

        // Stamp 26: channel 1 corrupted but unqualified.
        applyStimulus(1'b1, 1'b0, 4'b1101, 32'h0000_0100, 32'h0);
        afterEdge();
        checkOutput("masked A.fail_mask", 32'(maskA), 32'h0);
        checkOutput("masked A.first_valid", 32'(fvA), 32'h0);

        // Stamp 27 clean, stamp 28: channels 3 and 0 together.
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0100_0001, 32'h0);
        afterEdge();
        checkOutput("prio A.fail_mask", 32'(maskA), 32'h9);
        checkOutput("prio A.first_chan", 32'(fcA), 32'd0);
        checkOutput("prio A.first_cycle", fcycA, 32'd28);
        checkOutput("prio A.err_count[3]", 32'(errA[15:12]), 32'd1);

        // Stamps 29..48: 20 more errors on channel 0 saturate the 4-bit count.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0001, 32'h0);
        afterEdge();
        checkOutput("sat A.err_count[0]", 32'(errA[3:0]), 32'd15);
        checkOutput("sat A.first_cycle", fcycA, 32'd28);

        // Stamp 49: clear during an error drops that error.
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h0000_0001, 32'h0);
        afterEdge();
        checkOutput("clr-err A.fail_mask", 32'(maskA), 32'h0);
        checkOutput("clr-err A.err_count", 32'(errA), 32'h0);
        checkOutput("clr-err A.first_valid", 32'(fvA), 32'h0);

        // en drop: IDLE at stamp 50, FILL at 51/52, first CHECK at 53.
        // dutB compares on its very first enabled cycle.
        applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0100_0000);
        afterEdge();
        checkOutput("lat0 B.first_valid", 32'(fvB), 32'd1);
        checkOutput("lat0 B.first_chan", 32'(fcB), 32'd3);
        checkOutput("lat0 B.first_cycle", fcycB, 32'd50);
        checkOutput("lat0 B.fail_mask", 32'(maskB), 32'h8);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        afterEdge();
        checkOutput("fill A.fail_mask", 32'(maskA), 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        afterEdge();
        checkOutput("refill A.fail_mask", 32'(maskA), 32'h2);
        checkOutput("refill A.first_chan", 32'(fcA), 32'd1);
        checkOutput("refill A.first_cycle", fcycA, 32'd53);

        // Async reset while dutA sits in FILL with flags set.
        applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        pulseReset("midfill");

        // Stamp restarted from 0: an error at the fifth enabled cycle is stamp 4.
        for (int i = 0; i <= 4; i++)
            applyStimulus(1'b1, 1'b0, 4'hF, (i == 4) ? 32'h0000_0001 : 32'h0, 32'h0);
        afterEdge();
        checkOutput("post-reset A.first_valid", 32'(fvA), 32'd1);
        checkOutput("post-reset A.first_cycle", fcycA, 32'd4);
        checkOutput("post-reset A.first_chan", 32'(fcA), 32'd0);

        repeat (3) applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        afterEdge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
